// File: rtl/prim_alert_sender_mc.sv
// ----------------------------------------------------------------------------
// prim_alert_sender_mc
//   N-channel alert sender using the differential alert/ping protocol.
//   Each channel has its own handshake FSM with fatal (sticky) mode,
//   test-alert injection, a handshake-done pulse and signal-integrity flag.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous reset, active-low
//   alert_req_i   [NAlerts]      alert request per channel (level or pulse)
//   alert_test_i  [NAlerts]      single-cycle test alert, ORed with request
//   alert_rx_i    [4*NAlerts]    ch i: {ping_p, ping_n, ack_p, ack_n}
//   alert_tx_o    [2*NAlerts]    ch i: {alert_p, alert_n}, registered
//   alert_ack_o   [NAlerts]      1-cycle pulse when an alert handshake ends
//   alert_pend_o  [NAlerts]      alert latched, not yet sent
//   sigint_o      [NAlerts]      ping/ack pair integrity error, registered
//   alert_cnt_o   [CntW*NAlerts] saturating sent-alert counters
//                                (present only with PRIM_ALERT_SENDER_CNT_EN)
//
// Build option: define PRIM_ALERT_SENDER_CNT_EN to add alert_cnt_o.
// ----------------------------------------------------------------------------

// Differential pair decoder: optional 2-flop synchronizer, integrity check
// (p == n), and level output that holds its last valid value during errors.
module prim_alert_sender_mc_diff_dec #(
    parameter bit AsyncOn = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic diff_pi,
    input  logic diff_ni,
    output logic level_o,
    output logic sigint_o
);
    logic w_p, w_n;
    logic r_level;

    if (AsyncOn) begin : g_async
        logic [1:0] r_p_sync, r_n_sync;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_p_sync <= '0;
                r_n_sync <= '1;
            end else begin
                r_p_sync <= {r_p_sync[0], diff_pi};
                r_n_sync <= {r_n_sync[0], diff_ni};
            end
        end
        assign w_p = r_p_sync[1];
        assign w_n = r_n_sync[1];
    end else begin : g_sync
        assign w_p = diff_pi;
        assign w_n = diff_ni;
    end

    assign sigint_o = (w_p == w_n);
    assign level_o  = sigint_o ? r_level : w_p;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_level <= 1'b0;
        else         r_level <= level_o;
    end
endmodule

module prim_alert_sender_mc #(
    parameter int unsigned        NAlerts = 2,
    parameter logic [NAlerts-1:0] AsyncOn = '1,
    parameter logic [NAlerts-1:0] IsFatal = '0,
    parameter int unsigned        CntW    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NAlerts-1:0]     alert_req_i,
    input  logic [NAlerts-1:0]     alert_test_i,
    input  logic [4*NAlerts-1:0]   alert_rx_i,
    output logic [2*NAlerts-1:0]   alert_tx_o,
    output logic [NAlerts-1:0]     alert_ack_o,
    output logic [NAlerts-1:0]     alert_pend_o,
    output logic [NAlerts-1:0]     sigint_o
`ifdef PRIM_ALERT_SENDER_CNT_EN
    ,
    output logic [CntW*NAlerts-1:0] alert_cnt_o
`endif
);
    if (NAlerts < 1 || NAlerts > 32 || CntW < 1) begin : g_param_check
        $error("prim_alert_sender_mc: NAlerts must be 1..32 and CntW >= 1");
    end

    typedef enum logic [2:0] {
        Idle     = 3'd0,
        HsPhase1 = 3'd1,
        HsPhase2 = 3'd2,
        Pause0   = 3'd3,
        Pause1   = 3'd4,
        SigInt   = 3'd5
    } state_e;

    for (genvar gi = 0; gi < NAlerts; gi++) begin : g_ch
        logic   w_ping_level, w_ping_sigint, w_ack_level, w_ack_sigint;
        logic   w_sigint, w_ping_event, w_req;
        logic   r_ping_q;
        state_e r_state, w_state_d;
        logic   r_p, r_n, w_p_d, w_n_d;
        logic   r_alert_set, w_alert_set_d, r_ping_set, w_ping_set_d;
        logic   r_served_alert, w_served_alert_d;
        logic   r_ack, w_ack_d, r_sigint;
        logic   w_alert_clr, w_ping_clr;

        prim_alert_sender_mc_diff_dec #(
            .AsyncOn (AsyncOn[gi])
        ) u_ping_dec (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .diff_pi  (alert_rx_i[4*gi+3]),
            .diff_ni  (alert_rx_i[4*gi+2]),
            .level_o  (w_ping_level),
            .sigint_o (w_ping_sigint)
        );

        prim_alert_sender_mc_diff_dec #(
            .AsyncOn (AsyncOn[gi])
        ) u_ack_dec (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .diff_pi  (alert_rx_i[4*gi+1]),
            .diff_ni  (alert_rx_i[4*gi]),
            .level_o  (w_ack_level),
            .sigint_o (w_ack_sigint)
        );

        assign w_req        = alert_req_i[gi] | alert_test_i[gi];
        assign w_sigint     = w_ping_sigint | w_ack_sigint;
        // Ping requests are signalled by toggling the ping pair.
        assign w_ping_event = w_ping_level ^ r_ping_q;

        assign w_alert_set_d = (w_alert_clr && !IsFatal[gi]) ? 1'b0
                                                             : (r_alert_set | w_req);
        assign w_ping_set_d  = w_ping_clr ? 1'b0 : (r_ping_set | w_ping_event);

        always_comb begin
            w_state_d        = r_state;
            w_p_d            = 1'b0;
            w_n_d            = 1'b1;
            w_alert_clr      = 1'b0;
            w_ping_clr       = 1'b0;
            w_ack_d          = 1'b0;
            w_served_alert_d = r_served_alert;
            case (r_state)
                Idle: begin
                    if (w_req || r_alert_set || w_ping_event || r_ping_set) begin
                        w_state_d = HsPhase1;
                        w_p_d     = 1'b1;
                        w_n_d     = 1'b0;
                        // Pings win; a concurrent alert stays latched.
                        if (w_ping_event || r_ping_set) begin
                            w_ping_clr       = 1'b1;
                            w_served_alert_d = 1'b0;
                        end else begin
                            w_alert_clr      = 1'b1;
                            w_served_alert_d = 1'b1;
                        end
                    end
                end
                HsPhase1: begin
                    w_p_d = 1'b1;
                    w_n_d = 1'b0;
                    if (w_ack_level) begin
                        w_state_d = HsPhase2;
                        w_p_d     = 1'b0;
                        w_n_d     = 1'b1;
                    end
                end
                HsPhase2: begin
                    if (!w_ack_level) begin
                        w_state_d = Pause0;
                        w_ack_d   = r_served_alert;
                    end
                end
                Pause0: w_state_d = Pause1;
                Pause1: w_state_d = Idle;
                SigInt: begin
                    if (w_sigint) begin
                        w_p_d = ~r_p;
                        w_n_d = ~r_p;
                    end else begin
                        w_state_d = Idle;
                    end
                end
                default: w_state_d = Idle;
            endcase
            // Integrity error overrides everything; clears are withheld so
            // pending work is re-sent after recovery.
            if (w_sigint && r_state != SigInt) begin
                w_state_d        = SigInt;
                w_p_d            = 1'b0;
                w_n_d            = 1'b0;
                w_alert_clr      = 1'b0;
                w_ping_clr       = 1'b0;
                w_ack_d          = 1'b0;
                w_served_alert_d = r_served_alert;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state        <= Idle;
                r_p            <= 1'b0;
                r_n            <= 1'b1;
                r_alert_set    <= 1'b0;
                r_ping_set     <= 1'b0;
                r_served_alert <= 1'b0;
                r_ack          <= 1'b0;
                r_sigint       <= 1'b0;
                r_ping_q       <= 1'b0;
            end else begin
                r_state        <= w_state_d;
                r_p            <= w_p_d;
                r_n            <= w_n_d;
                r_alert_set    <= w_alert_set_d;
                r_ping_set     <= w_ping_set_d;
                r_served_alert <= w_served_alert_d;
                r_ack          <= w_ack_d;
                r_sigint       <= w_sigint;
                r_ping_q       <= w_ping_level;
            end
        end

        assign alert_tx_o[2*gi+1] = r_p;
        assign alert_tx_o[2*gi]   = r_n;
        assign alert_ack_o[gi]    = r_ack;
        assign alert_pend_o[gi]   = r_alert_set;
        assign sigint_o[gi]       = r_sigint;

`ifdef PRIM_ALERT_SENDER_CNT_EN
        logic [CntW-1:0] r_cnt;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (r_ack && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
        assign alert_cnt_o[gi*CntW +: CntW] = r_cnt;
`endif
    end
endmodule

// File: tb/tb_prim_alert_sender_mc.sv
// ----------------------------------------------------------------------------
// tb_prim_alert_sender_mc
//   Directed bench for prim_alert_sender_mc with NAlerts=2, synchronous
//   decoders, channel 1 fatal. Inputs change 1 time unit after the rising
//   edge; outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_prim_alert_sender_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, tst;
    logic [7:0]  rx;
    logic [3:0]  tx;
    logic [1:0]  ack, pend, sig;
`ifdef PRIM_ALERT_SENDER_CNT_EN
    logic [15:0] cnt;
`endif
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    prim_alert_sender_mc #(
        .NAlerts (2),
        .AsyncOn (2'b00),
        .IsFatal (2'b10),
        .CntW    (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .alert_req_i  (req),
        .alert_test_i (tst),
        .alert_rx_i   (rx),
        .alert_tx_o   (tx),
        .alert_ack_o  (ack),
        .alert_pend_o (pend),
        .sigint_o     (sig)
`ifdef PRIM_ALERT_SENDER_CNT_EN
        ,
        .alert_cnt_o  (cnt)
`endif
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ack(input int ch, input logic v);
        rx[4*ch+1] = v;
        rx[4*ch]   = ~v;
    endtask

    task automatic set_ping(input int ch, input logic v);
        rx[4*ch+3] = v;
        rx[4*ch+2] = ~v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        tst   = '0;
        rx    = 8'h55;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        chk_eq("rst_tx",   tx,   4'b0101);
        chk_eq("rst_ack",  ack,  2'b00);
        chk_eq("rst_pend", pend, 2'b00);
        chk_eq("rst_sig",  sig,  2'b00);

        // Plain alert on ch0, ack after 4 cycles of {1,0}
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        chk_eq("t1_tx0_c1", tx[1:0], 2'b10);
        chk_eq("t1_pend",   pend,    2'b00);
        chk_eq("t1_tx1",    tx[3:2], 2'b01);
        tick(); chk_eq("t1_tx0_c2", tx[1:0], 2'b10);
        tick(); chk_eq("t1_tx0_c3", tx[1:0], 2'b10);
        tick(); chk_eq("t1_tx0_c4", tx[1:0], 2'b10);
        set_ack(0, 1'b1);
        tick();
        chk_eq("t1_tx0_ph2", tx[1:0], 2'b01);
        chk_eq("t1_ack_ph2", ack,     2'b00);
        set_ack(0, 1'b0);
        tick();
        chk_eq("t1_ack_pulse", ack,     2'b01);
        chk_eq("t1_tx0_p0",    tx[1:0], 2'b01);
        tick();
        chk_eq("t1_ack_once", ack,     2'b00);
        chk_eq("t1_pend_end", pend,    2'b00);
        chk_eq("t1_tx1_end",  tx[3:2], 2'b01);
        tick();

        // Ping and alert in the same cycle: ping first, then the alert
        set_ping(0, 1'b1);
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        chk_eq("t2_tx0_ping", tx[1:0], 2'b10);
        chk_eq("t2_pend",     pend[0], 1'b1);
        set_ack(0, 1'b1);
        tick();
        chk_eq("t2_tx0_ph2", tx[1:0], 2'b01);
        set_ack(0, 1'b0);
        tick();
        chk_eq("t2_noack_p0", ack, 2'b00);
        tick();
        chk_eq("t2_noack_p1", ack,     2'b00);
        chk_eq("t2_pend_p1",  pend[0], 1'b1);
        tick();
        chk_eq("t2_tx0_idle", tx[1:0], 2'b01);
        tick();
        chk_eq("t2_tx0_alert", tx[1:0], 2'b10);
        chk_eq("t2_pend_clr",  pend[0], 1'b0);
        set_ack(0, 1'b1);
        tick();
        set_ack(0, 1'b0);
        tick();
        chk_eq("t2_ack_alert", ack, 2'b01);
        tick();
        tick();

        // Integrity error on ack pair mid-handshake, latched test alert re-sent
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        tst[0] = 1'b1;
        tick();
        tst[0] = 1'b0;
        chk_eq("t3_pend",   pend[0], 1'b1);
        chk_eq("t3_tx0_h1", tx[1:0], 2'b10);
        rx[1:0] = 2'b11;
        tick();
        chk_eq("t3_tx0_s0", tx[1:0], 2'b00);
        chk_eq("t3_sig",    sig,     2'b01);
        tick();
        chk_eq("t3_tx0_s1", tx[1:0], 2'b11);
        tick();
        chk_eq("t3_tx0_s2", tx[1:0], 2'b00);
        set_ack(0, 1'b0);
        tick();
        chk_eq("t3_tx0_idle", tx[1:0], 2'b01);
        chk_eq("t3_sig_clr",  sig,     2'b00);
        chk_eq("t3_pend_kept", pend[0], 1'b1);
        tick();
        chk_eq("t3_tx0_resend", tx[1:0], 2'b10);
        chk_eq("t3_pend_clr",   pend[0], 1'b0);
        set_ack(0, 1'b1);
        tick();
        set_ack(0, 1'b0);
        tick();
        chk_eq("t3_ack", ack, 2'b01);
        tick();
        tick();

        // Fatal ch1: one request, endless re-send
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        chk_eq("t4_tx1_h1", tx[3:2], 2'b10);
        chk_eq("t4_pend",   pend,    2'b10);
        chk_eq("t4_tx0",    tx[1:0], 2'b01);
        set_ack(1, 1'b1);
        tick();
        chk_eq("t4_tx1_h2", tx[3:2], 2'b01);
        set_ack(1, 1'b0);
        tick();
        chk_eq("t4_ack1", ack, 2'b10);
        tick();
        chk_eq("t4_ack1_once", ack,  2'b00);
        chk_eq("t4_pend_p1",   pend, 2'b10);
        tick();
        chk_eq("t4_tx1_idle", tx[3:2], 2'b01);
        tick();
        chk_eq("t4_tx1_loop2", tx[3:2], 2'b10);
        chk_eq("t4_pend_loop2", pend,   2'b10);
        set_ack(1, 1'b1);
        tick();
        set_ack(1, 1'b0);
        tick();
        chk_eq("t4_ack1_loop2", ack, 2'b10);
        tick();
        tick();
        tick();
        chk_eq("t4_tx1_loop3", tx[3:2], 2'b10);
        set_ack(1, 1'b1);
        tick();
        chk_eq("t4_tx1_loop3_h2", tx[3:2], 2'b01);

        // Asynchronous reset during HsPhase2
        #2 rst_n = 1'b0;
        set_ping(0, 1'b0);
        #1;
        chk_eq("t5_tx",   tx,   4'b0101);
        chk_eq("t5_pend", pend, 2'b00);
        chk_eq("t5_ack",  ack,  2'b00);
        chk_eq("t5_sig",  sig,  2'b00);
        set_ack(1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_eq("t5_pend_lost", pend, 2'b00);
        chk_eq("t5_tx_idle",   tx,   4'b0101);

`ifdef PRIM_ALERT_SENDER_CNT_EN
        chk_eq("t6_cnt_rst", cnt, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            req[0] = 1'b1;
            tick();
            req[0] = 1'b0;
            set_ack(0, 1'b1);
            tick();
            set_ack(0, 1'b0);
            tick();
            tick();
            tick();
            if (i == 254) chk_eq("t6_cnt_255", cnt, 16'h00ff);
        end
        chk_eq("t6_cnt_sat", cnt, 16'h00ff);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
